// File: rtl/wavegen.sv
`default_nettype none
// ============================================================================
// Module   : wavegen
// Function : Multi-mode waveform generator (triangle, saw up, saw down, square)
//            with runtime-programmable step. Optional macro WAVEGEN_SYNC_EN
//            adds the registered period-start pulse o_sync.
// Revision : 1.0 - initial release
// ============================================================================
module wavegen #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_holdn,
  input  logic             i_cfg_valid,
  input  logic [1:0]       i_cfg_mode,
  input  logic [WIDTH-1:0] i_cfg_step,
  output logic [WIDTH-1:0] o_out,
  output logic             o_rising
`ifdef WAVEGEN_SYNC_EN
  ,
  output logic             o_sync
`endif
);

  localparam logic [WIDTH-1:0] c_MAX  = '1;
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_MODE_TRI    = 2'b00;
  localparam logic [1:0] c_MODE_SAW_UP = 2'b01;
  localparam logic [1:0] c_MODE_SAW_DN = 2'b10;
  localparam logic [1:0] c_MODE_SQUARE = 2'b11;

  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_dir;
  logic             w_advance;

  assign w_advance = i_holdn && (r_step != c_ZERO);

  // Extremes are clamped rather than overshot so each peak lasts one cycle.
  always_comb begin
    w_next_count = r_count;
    w_next_dir   = r_dir;
    case (r_mode)
      c_MODE_SAW_UP: begin
        if (r_count > c_MAX - r_step) w_next_count = c_ZERO;
        else                          w_next_count = r_count + r_step;
      end
      c_MODE_SAW_DN: begin
        if (r_count < r_step) w_next_count = c_MAX;
        else                  w_next_count = r_count - r_step;
      end
      default: begin
        if (r_dir) begin
          if (r_count >= c_MAX - r_step) begin
            w_next_count = c_MAX;
            w_next_dir   = 1'b0;
          end else begin
            w_next_count = r_count + r_step;
          end
        end else begin
          if (r_count <= r_step) begin
            w_next_count = c_ZERO;
            w_next_dir   = 1'b1;
          end else begin
            w_next_count = r_count - r_step;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode  <= c_MODE_TRI;
      r_step  <= c_ONE;
      r_count <= c_ZERO;
      r_dir   <= 1'b1;
    end else if (i_cfg_valid) begin
      r_mode  <= i_cfg_mode;
      r_step  <= i_cfg_step;
      r_count <= c_ZERO;
      r_dir   <= 1'b1;
    end else if (w_advance) begin
      r_count <= w_next_count;
      r_dir   <= w_next_dir;
    end
  end

  always_comb begin
    o_out = r_count;
    if (r_mode == c_MODE_SQUARE) o_out = r_dir ? c_MAX : c_ZERO;
  end

  assign o_rising = r_dir;

`ifdef WAVEGEN_SYNC_EN
  logic r_sync;
  logic w_period_start;

  // Period start: saw wraps, or the triangle/square bottom turn-around.
  always_comb begin
    case (r_mode)
      c_MODE_SAW_UP: w_period_start = (r_count > c_MAX - r_step);
      c_MODE_SAW_DN: w_period_start = (r_count < r_step);
      default:       w_period_start = !r_dir && (r_count <= r_step);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)            r_sync <= 1'b0;
    else if (i_cfg_valid) r_sync <= 1'b1;
    else if (w_advance)   r_sync <= w_period_start;
    else                  r_sync <= 1'b0;
  end

  assign o_sync = r_sync;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wavegen.sv
`default_nettype none
// ============================================================================
// Module   : tb_wavegen
// Function : Scoreboard bench for wavegen (WIDTH=8), sync checked when
//            WAVEGEN_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wavegen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       holdn = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic [7:0] cfg_step = 8'd1;
  logic [7:0] o_out;
  logic       o_rising;
  logic       sync_obs;

`ifdef WAVEGEN_SYNC_EN
  localparam bit c_SYNC_EN = 1'b1;
  logic sync_w;
  assign sync_obs = sync_w;
`else
  localparam bit c_SYNC_EN = 1'b0;
  assign sync_obs = 1'b0;
`endif

  wavegen #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_holdn     (holdn),
    .i_cfg_valid (cfg_valid),
    .i_cfg_mode  (cfg_mode),
    .i_cfg_step  (cfg_step),
    .o_out       (o_out),
    .o_rising    (o_rising)
`ifdef WAVEGEN_SYNC_EN
    ,
    .o_sync      (sync_w)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] o;
    logic       r;
    logic       s;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  // Drive one cycle of stimulus, push its expected result, advance past the edge.
  task automatic apply(input logic a_rst, input logic a_cfg, input logic [1:0] a_mode,
                       input logic [7:0] a_step, input logic a_holdn,
                       input logic [7:0] eo, input logic er, input logic es);
    exp_t x;
    rst = a_rst; cfg_valid = a_cfg; cfg_mode = a_mode; cfg_step = a_step; holdn = a_holdn;
    x.o = eo; x.r = er; x.s = es & c_SYNC_EN;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, (i == 1), 2'b01, 8'd9, 1'b1, 8'd0, 1'b1, 1'b0);
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL reset i=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 i, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_triangle_default();
    logic [7:0] eo; logic er; logic es;
    for (int k = 1; k <= 511; k++) begin
      if (k <= 255)      begin eo = 8'(k);       er = (k < 255); es = 1'b0; end
      else if (k <= 510) begin eo = 8'(510 - k); er = (k == 510); es = (k == 510); end
      else               begin eo = 8'd1;        er = 1'b1;      es = 1'b0; end
      apply(1'b0, 1'b0, 2'b00, 8'd0, 1'b1, eo, er, es);
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL tri_default k=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 k, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_triangle_step100();
    logic [7:0] to[8] = '{8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
    logic       tr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ts[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, (i == 0), 2'b00, 8'd100, 1'b1, to[i], tr[i], ts[i]);
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL tri_step100 i=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 i, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_saw_up();
    logic [7:0] to[9] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64, 8'd128, 8'd192, 8'd0};
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, (i == 0), 2'b01, 8'd64, 1'b1, to[i], 1'b1, (to[i] == 8'd0));
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL saw_up i=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 i, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_saw_down();
    logic [7:0] eo; logic es;
    // cfg edge, 255, 252..3 (84 values), 0, 255
    for (int k = 0; k <= 87; k++) begin
      if (k == 0)       begin eo = 8'd0;             es = 1'b1; end
      else if (k <= 85) begin eo = 8'(255 - 3*(k-1)); es = (k == 1); end
      else if (k == 86) begin eo = 8'd0;             es = 1'b0; end
      else              begin eo = 8'd255;           es = 1'b1; end
      apply(1'b0, (k == 0), 2'b10, 8'd3, 1'b1, eo, 1'b1, es);
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL saw_down k=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 k, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_square();
    logic [7:0] eo; logic er; logic es;
    for (int k = 0; k <= 510; k++) begin
      if (k <= 254)      begin eo = 8'd255; er = 1'b1; es = (k == 0); end
      else if (k <= 509) begin eo = 8'd0;   er = 1'b0; es = 1'b0;     end
      else               begin eo = 8'd255; er = 1'b1; es = 1'b1;     end
      apply(1'b0, (k == 0), 2'b11, 8'd1, 1'b1, eo, er, es);
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL square k=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 k, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] eo; logic cfg; logic hn; logic es;
    // 0..37, hold x10, resume 38, hold+cfg -> 0, hold x3, resume 1
    for (int k = 0; k <= 53; k++) begin
      cfg = 1'b0; hn = 1'b1; es = 1'b0;
      if (k == 0)       begin cfg = 1'b1; eo = 8'd0; es = 1'b1; end
      else if (k <= 37) eo = 8'(k);
      else if (k <= 47) begin hn = 1'b0; eo = 8'd37; end
      else if (k == 48) eo = 8'd38;
      else if (k == 49) begin hn = 1'b0; cfg = 1'b1; eo = 8'd0; es = 1'b1; end
      else if (k <= 52) begin hn = 1'b0; eo = 8'd0; end
      else              eo = 8'd1;
      apply(1'b0, cfg, 2'b00, 8'd1, hn, eo, 1'b1, es);
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL hold k=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 k, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_reset_cfg();
    logic [7:0] to[8] = '{8'd0, 8'd7, 8'd14, 8'd21, 8'd0, 8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 8; i++) begin
      apply((i == 4), (i == 0 || i == 4), (i == 4) ? 2'b01 : 2'b01, (i == 4) ? 8'd5 : 8'd7,
            1'b1, to[i], 1'b1, (i == 0));
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL reset_cfg i=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 i, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  task automatic test_step_zero();
    logic [1:0] m; logic [7:0] eo;
    for (int k = 0; k < 30; k++) begin
      m  = (k < 15) ? 2'b00 : 2'b11;
      eo = (k < 15) ? 8'd0 : 8'd255;
      apply(1'b0, (k == 0 || k == 15), m, 8'd0, 1'b1, eo, 1'b1, (k == 0 || k == 15));
      e = sb.pop_front(); vectors++;
      if ({o_out, o_rising, sync_obs} !== {e.o, e.r, e.s}) begin
        miscompares++;
        $display("FAIL step_zero k=%0d got out=%0d rising=%0b sync=%0b want out=%0d rising=%0b sync=%0b",
                 k, o_out, o_rising, sync_obs, e.o, e.r, e.s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_triangle_default();
    test_triangle_step100();
    test_saw_up();
    test_saw_down();
    test_square();
    test_hold();
    test_reset_cfg();
    test_step_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
